node_mac_seq: RTL and testbench
===============================

Name: node_mac_seq

Overview:
- Sequential, parametrised successor to the fully-parallel float neuron node.
- Streams N_IN single-precision inputs through one float_mult and one float_adder.
- Accumulates the weighted sum plus a bias, then applies optional ReLU.
- Presents the result on a valid/ready output; one instance per neuron, time-multiplexed over its inputs instead of N_IN multipliers and a log-depth adder tree.

Parameters:
- N_IN, 187, number of inputs/weights per neuron (≥1).
- AW, $clog2(N_IN) (min 1), weight address / input counter width.
- BIAS, 32'h00000000, IEEE-754 single bias; the accumulator starts from this value.
- RELU_EN, 1, 1 = clamp negative result to +0; 0 = pass raw sum.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight write strobe.
- w_addr  in  AW  weight index (0..N_IN-1).
- w_data  in  32  weight value (IEEE-754 single).
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  input activation (IEEE-754 single).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  neuron output N.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; acc=BIAS; prod_q=0; out_valid=0; out_data=0; busy=0. The weight RAM (N_IN x 32 registers) is not reset.
- Weight writes:
  - Accepted only in IDLE, and only when w_addr < N_IN; otherwise ignored.
  - Write takes effect on the next edge.
- State IDLE:
  - in_ready=1.
  - On in_valid: the sample is accepted as index 0, acc loads BIAS, go to ACCUM.
- State ACCUM:
  - in_ready=1 while counter < N_IN.
  - Each accepted sample k: prod_q <= in_data * W[k] (float_mult, registered); counter++.
  - Every cycle a valid product is held in prod_q: acc <= acc + prod_q (float_adder, registered); the product valid flag then clears.
  - Gaps in in_valid are allowed; prod/add pipe stalls with no loss.
  - When sample N_IN-1 is accepted: in_ready=0 next cycle, go to DRAIN.
- State DRAIN: one cycle to fold the final prod_q into acc, then go to OUT.
- State OUT:
  - out_data = (RELU_EN && acc[31]) ? 32'h0 : acc. -0.0 also maps to +0.
  - out_valid=1 and out_data are held stable until out_ready=1.
  - On handshake: out_valid=0, counter=0, go to IDLE.
  - in_ready=0 throughout.
- Latency: last sample accepted at cycle T → acc final at T+2 → out_valid high from T+3.
- Back-to-back operation: a new sample may be accepted in IDLE the cycle after the handshake. There is no overlap of successive neurons.
- NaN/Inf inputs propagate per float_mult/float_adder; the ReLU tests only the sign bit.
- Reset mid-operation (any state): immediate return to reset values; the partial sum is discarded and weights are retained.
- in_valid while in_ready=0: ignored; the data is not consumed.

Decomposition:
- Shared package nn_pkg holds:
  - FP_W=32, FP_ZERO=32'h0, FP_ONE=32'h3F800000.
  - Sign-bit index 31.
  - State enum {IDLE, ACCUM, DRAIN, OUT}.
- Reuse existing float_mult and float_adder unchanged, one instance each.
- One natural sub-module: node_weight_ram (N_IN x 32, sync write, async read).

Test Plan:
- N_IN=4, BIAS=0, weights all 32'h40000000 (2.0), inputs 4x 32'h3F800000 (1.0) → out_data=32'h41000000 (8.0), out_valid exactly 3 cycles after the 4th accept.
- Same weights, inputs 4x 32'hBF800000 (-1.0), RELU_EN=1 → out_data=32'h00000000. Repeat with RELU_EN=0 → 32'hC1000000.
- BIAS=32'h3F800000, inputs all 0 → out_data=32'h3F800000. The in_valid pattern 1,0,0,1,1,0,1 gives the same result and latency from the last accept.
- Backpressure: out_ready=0 for 10 cycles → out_valid stays 1, out_data stable, in_ready=0, extra in_valid pulses are not consumed. out_ready=1 → IDLE next cycle.
- w_we with w_data=32'h3F800000 during ACCUM → ignored, result still 8.0. w_addr=N_IN in IDLE → no RAM change.
- Assert rst_n=0 after 2 of 4 samples → busy=0 and out_valid=0 asynchronously. A fresh 4-sample run then gives 8.0 with the weights unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// ------------------------------------------------------------------
// nn_pkg : shared float constants and node state encoding
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package nn_pkg;
  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam int          FP_SIGN = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/float_adder.sv
// ------------------------------------------------------------------
// float_adder : combinational IEEE-754 single add, RNE, FTZ
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] x, z;
  logic        sub, g, st, rnd;
  logic [7:0]  d, dd;
  logic [26:0] mx, mz, mask, mzs, sum_n;
  logic [27:0] sum;
  logic [4:0]  msb, lz;
  logic [9:0]  e;
  logic [22:0] m;
  logic [23:0] mr;

  always_comb begin
    // x always carries the larger magnitude, so the result takes its sign
    if (a[30:0] >= b[30:0]) begin
      x = a;
      z = b;
    end else begin
      x = b;
      z = a;
    end
    sub  = x[31] ^ z[31];
    d    = x[30:23] - z[30:23];
    dd   = (d > 8'd27) ? 8'd27 : d;
    mx   = {1'b1, x[22:0], 3'b0};
    mz   = {1'b1, z[22:0], 3'b0};
    mask = (27'd1 << dd) - 27'd1;
    mzs  = (mz >> dd) | {26'b0, |(mz & mask)};
    sum  = sub ? ({1'b0, mx} - {1'b0, mzs}) : ({1'b0, mx} + {1'b0, mzs});
    msb  = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) msb = 5'(i);
    lz    = 5'd26 - msb;
    sum_n = sum[26:0] << lz;
    e     = {2'b0, x[30:23]};
    if (sum[27]) begin
      e  = e + 10'd1;
      m  = sum[26:4];
      g  = sum[3];
      st = |sum[2:0];
    end else begin
      e  = e - {5'b0, lz};
      m  = sum_n[25:3];
      g  = sum_n[2];
      st = |sum_n[1:0];
    end
    rnd = g & (st | m[0]);
    mr  = {1'b0, m} + {23'b0, rnd};
    if (mr[23]) e = e + 10'd1;

    if (&x[30:23])
      y = (&z[30:23] && sub) ? 32'h7FC0_0000 : x;
    else if (~|x[30:23])
      y = {x[31] & z[31], 31'b0};
    else if (~|z[30:23])
      y = x;
    else if (sum == 28'd0 || $signed(e) <= $signed(10'sd0))
      y = {(sum == 28'd0) ? 1'b0 : x[31], 31'b0};
    else if ($signed(e) >= $signed(10'sd255))
      y = {x[31], 8'hFF, 23'b0};
    else
      y = {x[31], e[7:0], mr[22:0]};
  end
endmodule

`default_nettype wire

// File: rtl/float_mult.sv
// ------------------------------------------------------------------
// float_mult : combinational IEEE-754 single multiply, RNE, FTZ
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        s, g, st, rnd;
  logic [47:0] p;
  logic [9:0]  e;
  logic [22:0] m;
  logic [23:0] mr;

  always_comb begin
    s   = a[31] ^ b[31];
    p   = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e   = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    m   = p[45:23];
    g   = p[22];
    st  = |p[21:0];
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'd1;
    end
    rnd = g & (st | m[0]);
    mr  = {1'b0, m} + {23'b0, rnd};
    if (mr[23]) e = e + 10'd1;

    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) ||
        (&a[30:23] && ~|b[30:23]) || (&b[30:23] && ~|a[30:23]))
      y = 32'h7FC0_0000;
    else if (&a[30:23] || &b[30:23])
      y = {s, 8'hFF, 23'b0};
    else if (~|a[30:23] || ~|b[30:23])
      y = {s, 31'b0};
    else if ($signed(e) <= $signed(10'sd0))
      y = {s, 31'b0};
    else if ($signed(e) >= $signed(10'sd255))
      y = {s, 8'hFF, 23'b0};
    else
      y = {s, e[7:0], mr[22:0]};
  end
endmodule

`default_nettype wire

// File: rtl/node_weight_ram.sv
// ------------------------------------------------------------------
// node_weight_ram : per-neuron weight store, sync write, async read
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module node_weight_ram
  import nn_pkg::*;
#(
  parameter int DEPTH = 187,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [FP_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [FP_W-1:0] rdata
);
  logic [FP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

`default_nettype wire

// File: rtl/node_mac_seq.sv
// ------------------------------------------------------------------
// node_mac_seq : time-multiplexed float neuron (sum w*x + bias, ReLU)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module node_mac_seq
  import nn_pkg::*;
#(
  parameter int          N_IN    = 187,
  parameter int          AW      = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter logic [31:0] BIAS    = 32'h0000_0000,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [FP_W-1:0] w_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic            busy
);
  localparam logic [AW:0] CNT_MAX  = (AW+1)'(N_IN);
  localparam logic [AW:0] CNT_LAST = CNT_MAX - (AW+1)'(1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [FP_W-1:0] acc_q, acc_d, prod_q, prod_d, out_data_q, out_data_d;
  logic            pv_q, pv_d, out_valid_q, out_valid_d;
  logic [FP_W-1:0] w_rdata, w_prod, w_sum;
  logic            w_accept, w_wr_en;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM && cnt_q < CNT_MAX);
  assign w_accept  = in_valid && in_ready;
  assign w_wr_en   = w_we && (state_q == IDLE) && ({1'b0, w_addr} < CNT_MAX);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  node_weight_ram #(.DEPTH(N_IN), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (cnt_q[AW-1:0]),
    .rdata (w_rdata)
  );

  float_mult  u_mult (.a(in_data), .b(w_rdata), .y(w_prod));
  float_adder u_add  (.a(acc_q),   .b(prod_q),  .y(w_sum));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    pv_d        = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // a held product folds in the same cycle a new one may be captured
    if (pv_q) acc_d = w_sum;
    if (w_accept) begin
      prod_d = w_prod;
      pv_d   = 1'b1;
      cnt_d  = cnt_q + CNT_ONE;
    end
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          acc_d   = BIAS;
          state_d = (cnt_q == CNT_LAST) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && cnt_q == CNT_LAST) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = (RELU_EN && acc_q[FP_SIGN]) ? FP_ZERO : acc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= BIAS;
      prod_q      <= FP_ZERO;
      pv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= FP_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_node_mac_seq.sv
// ------------------------------------------------------------------
// tb_node_mac_seq : directed bench, three parameter variants in lockstep
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_node_mac_seq;
  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] FM1 = 32'hBF80_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] FM8 = 32'hC100_0000;
  localparam logic [31:0] F9  = 32'h4110_0000;

  logic        clk = 1'b0, rst_n = 1'b0, w_we = 1'b0;
  logic [2:0]  w_addr = 3'd0;
  logic [31:0] w_data = '0, in_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        busy_a, busy_b, busy_c;
  logic [31:0] out_data_a, out_data_b, out_data_c;

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: ReLU, zero bias; b: raw sum; c: ReLU, bias 1.0
  node_mac_seq #(.N_IN(4), .AW(3), .BIAS(32'h0), .RELU_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a));
  node_mac_seq #(.N_IN(4), .AW(3), .BIAS(32'h0), .RELU_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b));
  node_mac_seq #(.N_IN(4), .AW(3), .BIAS(32'h3F80_0000), .RELU_EN(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] x, input logic [7:0] pat, input int plen, input bit wr_noise);
    for (int i = 0; i < plen; i++) begin
      in_valid = pat[i];
      in_data  = x;
      w_we     = wr_noise && busy_a;
      w_addr   = 3'd1;
      w_data   = F1;
      if (pat[i] && in_ready_a) acc_cyc = cyc;
      step();
    end
    in_valid = 1'b0;
    w_we     = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid_a && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(cyc - acc_cyc), 32'd3);
    chk({tag, " valid_bc"}, {30'b0, out_valid_b, out_valid_c}, 32'd3);
  endtask

  task automatic check_out(input string tag, input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    chk({tag, " data_a"}, out_data_a, ea);
    chk({tag, " data_b"}, out_data_b, eb);
    chk({tag, " data_c"}, out_data_c, ec);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle busy"}, 32'(busy_a), 32'd0);
    chk({tag, " idle valid"}, 32'(out_valid_a), 32'd0);
    chk({tag, " idle ready"}, 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst valid", 32'(out_valid_a), 32'd0);
    chk("rst data", out_data_a, F0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst ready", 32'(in_ready_a), 32'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      w_we   = 1'b1;
      w_addr = 3'(i);
      w_data = F2;
      step();
    end
    w_we = 1'b0;

    feed(F1, 8'h0F, 4, 1'b0);
    wait_valid("pos");
    check_out("pos", F8, F8, F9);
    handshake("pos");

    feed(FM1, 8'h0F, 4, 1'b0);
    wait_valid("neg");
    check_out("neg", F0, FM8, F0);
    handshake("neg");

    // gapped valid pattern 1,0,0,1,1,0,1
    feed(F0, 8'b0101_1001, 7, 1'b0);
    wait_valid("gap");
    check_out("gap", F0, F0, F1);
    handshake("gap");

    feed(F1, 8'h0F, 4, 1'b0);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = FM1;
      step();
      chk("bp valid", 32'(out_valid_a), 32'd1);
      chk("bp data", out_data_a, F8);
      chk("bp ready", 32'(in_ready_a), 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");

    feed(F1, 8'h0F, 4, 1'b1);
    wait_valid("wnoise");
    check_out("wnoise", F8, F8, F9);
    handshake("wnoise");

    w_we   = 1'b1;
    w_addr = 3'd4;
    w_data = F1;
    step();
    w_we = 1'b0;
    feed(F1, 8'h0F, 4, 1'b0);
    wait_valid("oob");
    check_out("oob", F8, F8, F9);
    handshake("oob");

    feed(F1, 8'h03, 2, 1'b0);
    chk("mid busy", 32'(busy_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy_a), 32'd0);
    chk("arst valid", 32'(out_valid_a), 32'd0);
    chk("arst ready", 32'(in_ready_a), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    feed(F1, 8'h0F, 4, 1'b0);
    wait_valid("fresh");
    check_out("fresh", F8, F8, F9);
    handshake("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
